// File: rtl/perm_ctrl_pkg.sv
// Shared opcode definitions and decode for the permutation join/fork controllers.
package perm_ctrl_pkg;

    localparam logic [3:0] OP_TO0   = 4'd1;
    localparam logic [3:0] OP_TO1   = 4'd5;
    localparam logic [3:0] OP_BCAST = 4'd7;

    typedef logic [1:0] perm_mask_t;

    typedef struct packed {
        logic       invalid;
        perm_mask_t mask;
    } op_dec_t;

    function automatic op_dec_t op_decode(input logic [3:0] k_ctrl);
        op_dec_t dec;
        dec.invalid = 1'b0;
        dec.mask    = 2'b00;
        case (k_ctrl)
            OP_TO0:   dec.mask = 2'b01;
            OP_TO1:   dec.mask = 2'b10;
            OP_BCAST: dec.mask = 2'b11;
            default:  dec.invalid = 1'b1;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/fork_done_flag.sv
// One fork branch: gates the downstream request and remembers that the branch has
// already taken the current token.
module fork_done_flag (
    input  logic clk,
    input  logic reset_n,
    input  logic tok_valid,
    input  logic sel,
    input  logic ack,
    input  logic fin,
    output logic req,
    output logic xfer,
    output logic done
);

    logic done_q;
    logic done_d;

    assign req  = tok_valid & sel & ~done_q;
    assign xfer = req & ack;
    assign done = done_q;

    // Retiring the token clears the flag, even when this branch took it in the same cycle.
    assign done_d = fin ? 1'b0 : (done_q | xfer);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/operm_ctrl_1_2.sv
// Output-side permutation controller: eagerly forks one data token to branch 0, branch 1
// or both, as selected by the kernel token, and counts invalid opcodes.
module operm_ctrl_1_2
    import perm_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_dat_req,
    output logic             t_dat_ack,
    input  logic             t_kp_req,
    output logic             t_kp_ack,
    input  logic [3:0]       k_ctrl,
    output logic             i0_dat_req,
    input  logic             i0_dat_ack,
    output logic             i1_dat_req,
    input  logic             i1_dat_ack,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    op_dec_t          dec;
    logic             tok;
    logic             tokValid;
    logic             fin;
    logic             x0;
    logic             x1;
    logic             done0;
    logic             done1;
    logic             errInc;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;

    assign dec      = op_decode(k_ctrl);
    assign tok      = t_dat_req & t_kp_req;
    assign tokValid = tok & ~dec.invalid;

    fork_done_flag u_branch0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tok_valid(tokValid),
        .sel      (dec.mask[0]),
        .ack      (i0_dat_ack),
        .fin      (fin),
        .req      (i0_dat_req),
        .xfer     (x0),
        .done     (done0)
    );

    fork_done_flag u_branch1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tok_valid(tokValid),
        .sel      (dec.mask[1]),
        .ack      (i1_dat_ack),
        .fin      (fin),
        .req      (i1_dat_req),
        .xfer     (x1),
        .done     (done1)
    );

    // Token retires once every selected branch is either already done or taking it now.
    assign fin = tokValid
               & (~dec.mask[0] | done0 | x0)
               & (~dec.mask[1] | done1 | x1);

    assign t_dat_ack = fin;
    assign t_kp_ack  = fin | (dec.invalid & t_kp_req);
    assign busy      = done0 | done1;

    // An invalid kernel token is consumed on its own, so it is counted whenever presented.
    assign errInc = dec.invalid & t_kp_req;
    assign err_d  = (errInc && (err_q != {CNT_W{1'b1}})) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;

endmodule

// File: tb/tb_operm_ctrl_1_2.sv
// Directed bench for operm_ctrl_1_2 built with a 2-bit error counter so saturation is reachable.
module tb_operm_ctrl_1_2;

    logic       clk;
    logic       reset_n;
    logic       t_dat_req;
    logic       t_dat_ack;
    logic       t_kp_req;
    logic       t_kp_ack;
    logic [3:0] k_ctrl;
    logic       i0_dat_req;
    logic       i0_dat_ack;
    logic       i1_dat_req;
    logic       i1_dat_ack;
    logic [1:0] err_cnt;
    logic       busy;

    int nChecks = 0;
    int nErrors = 0;

    operm_ctrl_1_2 #(.CNT_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_dat_req (t_dat_req),
        .t_dat_ack (t_dat_ack),
        .t_kp_req  (t_kp_req),
        .t_kp_ack  (t_kp_ack),
        .k_ctrl    (k_ctrl),
        .i0_dat_req(i0_dat_req),
        .i0_dat_ack(i0_dat_ack),
        .i1_dat_req(i1_dat_req),
        .i1_dat_ack(i1_dat_ack),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold its token steady while a delivery is partially done.
    logic       prevDatReq;
    logic       prevKpReq;
    logic [3:0] prevKctrl;
    always @(posedge clk) begin
        if (reset_n && busy) begin
            assert (t_dat_req === prevDatReq && t_kp_req === prevKpReq && k_ctrl === prevKctrl)
                else $error("[TB] upstream token changed while busy");
        end
        prevDatReq = t_dat_req;
        prevKpReq  = t_kp_req;
        prevKctrl  = k_ctrl;
    end

    task automatic applyStimulus(input logic datReq, input logic kpReq, input logic [3:0] op,
                                 input logic ack0, input logic ack1);
        t_dat_req  = datReq;
        t_kp_req   = kpReq;
        k_ctrl     = op;
        i0_dat_ack = ack0;
        i1_dat_ack = ack1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nChecks++;
        assert (observed === expected)
            else begin
                nErrors++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_err", {6'd0, err_cnt}, 8'd0);
        checkOutput("rst_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'd0);
        checkOutput("rst_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'd0);
        #12;
        reset_n = 1'b1;
        tick();

        // Op 1 streaming: one token per cycle to branch 0 only.
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("op1_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b01);
            checkOutput("op1_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b11);
            tick();
            checkOutput("op1_busy", {7'd0, busy}, 8'd0);
        end

        // Op 7 with branch 1 lagging by two cycles.
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        checkOutput("op7p_c0_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b11);
        checkOutput("op7p_c0_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b00);
        tick();
        checkOutput("op7p_c1_busy", {7'd0, busy}, 8'd1);
        checkOutput("op7p_c1_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b10);
        checkOutput("op7p_c1_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b00);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        checkOutput("op7p_c2_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b10);
        checkOutput("op7p_c2_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b11);
        tick();
        checkOutput("op7p_c3_busy", {7'd0, busy}, 8'd0);

        // Op 7 with both acks together: retires immediately, no flags set.
        checkOutput("op7b_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b11);
        checkOutput("op7b_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b11);
        tick();
        checkOutput("op7b_busy", {7'd0, busy}, 8'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("idle_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b00);
        tick();

        // Invalid opcodes: kernel token consumed alone, counter saturates at 3.
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        checkOutput("inv_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b10);
        checkOutput("inv_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b00);
        checkOutput("inv_err0", {6'd0, err_cnt}, 8'd0);
        tick();
        checkOutput("inv_err1", {6'd0, err_cnt}, 8'd1);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        checkOutput("inv_dat_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b10);
        checkOutput("inv_dat_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b00);
        tick();
        checkOutput("inv_err2", {6'd0, err_cnt}, 8'd2);
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        tick();
        checkOutput("inv_err3", {6'd0, err_cnt}, 8'd3);
        tick();
        tick();
        checkOutput("inv_err_sat", {6'd0, err_cnt}, 8'd3);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checkOutput("inv_err_hold", {6'd0, err_cnt}, 8'd3);

        // Op 5 stalled by branch 1 for four cycles: request held, nothing retires.
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("op5s_reqs", {6'd0, i1_dat_req, i0_dat_req}, 8'b10);
            checkOutput("op5s_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b00);
            tick();
            checkOutput("op5s_busy", {7'd0, busy}, 8'd0);
        end
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        checkOutput("op5_done_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b11);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();

        // Partial broadcast interrupted by an asynchronous reset mid-cycle.
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        tick();
        checkOutput("rstmid_busy_pre", {7'd0, busy}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", {7'd0, busy}, 8'd0);
        checkOutput("rstmid_err", {6'd0, err_cnt}, 8'd0);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        checkOutput("rstmid_redeliver", {6'd0, i1_dat_req, i0_dat_req}, 8'b11);
        checkOutput("rstmid_acks", {6'd0, t_kp_ack, t_dat_ack}, 8'b00);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        checkOutput("rstmid_fin", {6'd0, t_kp_ack, t_dat_ack}, 8'b11);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("final_busy", {7'd0, busy}, 8'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/operm_ctrl_1_2.md
Name: operm_ctrl_1_2

Overview:
- Output-side permutation controller: the fork counterpart of the input-side 2:1 join controller.
- Takes one data token (t_dat) plus one kernel/permutation token (t_kp, carrying k_ctrl).
- Delivers the data token to one or both downstream consumers (i0/i1), as selected by k_ctrl.
- Eager fork: per-branch completion flags let each branch accept independently. The upstream tokens are retired only when every selected branch has taken the data.
- Sits between the permutation datapath stage and the two downstream engine inputs.

Parameters:
- CNT_W, 8: width of the saturating invalid-opcode counter err_cnt.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- t_dat_req  in  1  upstream data token valid.
- t_dat_ack  out  1  upstream data token consumed this cycle.
- t_kp_req  in  1  kernel/permutation token valid.
- t_kp_ack  out  1  kernel token consumed this cycle.
- k_ctrl  in  4  opcode; qualified by t_kp_req.
- i0_dat_req  out  1  branch 0 data valid.
- i0_dat_ack  in  1  branch 0 accepts.
- i1_dat_req  out  1  branch 1 data valid.
- i1_dat_ack  in  1  branch 1 accepts.
- err_cnt  out  CNT_W  count of invalid opcodes consumed; saturating.
- busy  out  1  high while a token is partially delivered (any done flag set).

Behaviour:
- Handshake rule: a transfer occurs on any req/ack pair in a cycle where both are high. Acks may depend combinationally on reqs; reqs never depend on their own ack.
- Opcode decode (combinational from k_ctrl):
  - 1 → mask = branch 0 only.
  - 5 → mask = branch 1 only.
  - 7 → mask = both branches.
  - any other value → invalid.
- Token present: tok = t_dat_req & t_kp_req.
- State: registers done0 and done1, reset to 0.
- Output requests:
  - i0_dat_req = tok & ~invalid & mask[0] & ~done0.
  - i1_dat_req = tok & ~invalid & mask[1] & ~done1.
- Branch completion this cycle:
  - x0 = i0_dat_req & i0_dat_ack; x1 likewise.
  - fin = tok & ~invalid & (~mask[0] | done0 | x0) & (~mask[1] | done1 | x1).
- Flag update:
  - If fin: done0 and done1 clear to 0 next cycle.
  - Else: done0 <= done0 | x0 and done1 <= done1 | x1.
- Upstream acks:
  - t_dat_ack = fin.
  - t_kp_ack = fin | (invalid & t_kp_req).
- Invalid opcode handling:
  - The kp token is consumed alone; t_dat_req is not required and data is not acked.
  - No downstream req is raised.
  - err_cnt increments by 1 per consumed invalid token and saturates at all-ones.
- Latency: zero-cycle combinational path from reqs to downstream reqs.
  - Single-branch op or both acks in one cycle: token retires in the cycle it is presented.
  - Otherwise it retires in the cycle the last selected branch acks.
- Throughput: one token per cycle when all selected branches ack.
- Simultaneous acks on both branches (op 7) in the same cycle → fin that cycle; flags stay 0.
- A branch that is already done keeps its req low while the other branch is outstanding; no duplicate delivery.
- Upstream stability:
  - While busy, t_dat_req, t_kp_req and k_ctrl are stable (upstream protocol obligation).
  - The bench asserts this; RTL behaviour is undefined on violation.
- Reset mid-operation: flags and err_cnt clear immediately. A partially delivered broadcast is re-delivered in full after reset; duplication is accepted.
- Reset values: all reqs and acks 0 (tok low is forced by upstream reset); busy 0; err_cnt 0.
- busy = done0 | done1 (registered).

Decomposition:
- Package perm_ctrl_pkg holds:
  - opcode constants OP_TO0=4'd1, OP_TO1=4'd5, OP_BCAST=4'd7;
  - typedef perm_mask_t (2-bit branch mask);
  - decode function op_decode(k_ctrl) → {invalid, mask}, shared with the 2:1 join controller.
- One sub-module is natural: fork_done_flag, a single-branch done register with the req-gating logic, instantiated twice.
- Counter and decode stay in the top.

Test Plan:
- Op 1, both acks held high, token held 3 cycles → i0_dat_req high, i1 low, t_dat_ack and t_kp_ack high each cycle, 3 transfers, busy stays 0.
- Op 7, i0_dat_ack=1 and i1_dat_ack=0 for 2 cycles, then i1_dat_ack=1:
  - cycle 0: x0, done0 set;
  - cycle 1: i0_dat_req=0, busy=1;
  - cycle 2: fin, both upstream acks 1, flags clear, busy=0 next.
- Op 7 with both acks in the same cycle → fin in one cycle, done flags never set.
- k_ctrl=3, t_kp_req=1, t_dat_req=0 → t_kp_ack=1, t_dat_ack=0, no downstream req, err_cnt 0→1. With CNT_W=2, 5 invalids → err_cnt=3 (saturated).
- Op 5 with i1_dat_ack=0 for 4 cycles → i1_dat_req held high, no upstream acks, busy=0 (no partial delivery).
- Op 7 partial (done0=1) then reset_n pulsed low asynchronously mid-cycle → done flags, busy, err_cnt read 0 immediately. After release, the re-presented token drives i0_dat_req and i1_dat_req both high.
